vga_frame_buffer: RTL
=====================

Name: vga_frame_buffer

Overview:
- Pixel store directly upstream of vga_controller.
- Read port is driven by vga_controller's memory_address and returns pixel_color one cycle later.
- Write port takes (x,y,color) pixel writes from game/draw logic over a valid/ready handshake.
- A built-in clear sequencer fills the whole frame with one colour, one pixel per cycle.

Parameters:
- COLOR_DEPTH, 9, bits per pixel (3 per RGB channel)
- nX, 10, width of x coordinate
- nY, 9, width of y coordinate
- Mn, 19, width of linear memory address
- COLS, 640, pixels per row
- ROWS, 480, rows per frame

Ports:
- vga_clock  in  1  single clock for both ports (25 MHz pixel clock)
- resetn  in  1  asynchronous active-low reset
- rd_address  in  Mn  linear read address from vga_controller memory_address
- rd_color  out  COLOR_DEPTH  registered pixel colour for rd_address, to vga_controller pixel_color
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write port can accept
- wr_x  in  nX  write column
- wr_y  in  nY  write row
- wr_color  in  COLOR_DEPTH  write colour
- clr_start  in  1  one-cycle pulse starting a full-frame clear
- clr_color  in  COLOR_DEPTH  fill colour, sampled on clr_start
- busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write

Behaviour:
- Storage: COLS*ROWS words of COLOR_DEPTH bits, inferred synchronous RAM. Contents are not reset.
- Address mapping: addr = wr_y*COLS + wr_x, computed at Mn bits. This is identical to the vga_controller address translator, so a pixel written at (x,y) is read back when the scan reaches (x,y).
- Read:
  - rd_color <= mem[rd_address] every cycle; latency exactly 1 cycle.
  - rd_address >= COLS*ROWS returns 0.
- Reset values: rd_color=0, busy=0, clr_done=0, FSM=IDLE, clear counter=0.
- FSM states: IDLE, CLEAR.
- IDLE:
  - wr_ready=1.
  - Transfer occurs when wr_valid && wr_ready.
  - If wr_x<COLS and wr_y<ROWS, mem[addr] <= wr_color on that edge. Otherwise the write is accepted and silently dropped; no stall.
  - clr_start=1 latches clr_color, clears the counter and moves to CLEAR.
- Simultaneous wr transfer and clr_start in IDLE: the write is performed in that same cycle, and the clear then overwrites it.
- CLEAR:
  - busy=1, wr_ready=0.
  - Each cycle: mem[cnt] <= latched colour; cnt++.
  - When cnt==COLS*ROWS-1 is written: next state IDLE, clr_done=1 for exactly one cycle (the first IDLE cycle), busy=0 in that same cycle.
  - A full clear takes COLS*ROWS cycles (307200 at defaults). busy rises the cycle after clr_start.
  - clr_start during CLEAR is ignored; the colour is not re-latched.
- The read port is never stalled. A read during a clear returns old or new data per RAM read-during-write semantics: old data unless the optional feature is enabled.
- Reset asserted mid-clear: immediate abort to IDLE with busy=0. No clr_done. Partially cleared contents remain.
- Widths: the clear counter is Mn bits. The mult/add for addr is truncated to Mn bits after the range check.

Optional Feature:
- Macro: FB_RDW_BYPASS_EN.
- When defined: if the write address (handshake write or clear write) equals rd_address in the same cycle, rd_color next cycle returns the newly written colour. This is implemented with a compare-and-mux bypass register.
- When undefined: same-address read-during-write returns the old memory contents.
- In both modes, different-address behaviour is identical.

Test Plan:
- Reset, then write (x=5,y=2,color=9'h1C7) with wr_valid=1 → wr_ready=1. rd_address=1285 the next cycle → rd_color=9'h1C7 one cycle later.
- Write with x=640,y=0 then x=0,y=480 → both accepted (wr_ready=1), no memory change. rd_address=0 and rd_address=640 keep prior values.
- clr_start with clr_color=9'h038 → busy=1 next cycle, wr_ready=0 for 307200 cycles, clr_done pulses once. rd_address 0, 320000-1→(clamped 0), 307199 read 9'h038, 0, 9'h038 respectively.
- Assert resetn=0 at clear cycle 1000, then release → busy=0, no clr_done. Addresses 0..999 hold the clear colour; address 5000 holds its old value.
- Same-cycle wr (addr 10, 9'h0FF) and rd_address=10 → rd_color=9'h0FF with FB_RDW_BYPASS_EN, old value without it.
- clr_start and a wr transfer in the same IDLE cycle, plus a second clr_start mid-clear with another colour → the entire frame ends at the first clr_color, and exactly one clr_done pulse occurs.

Source files
------------

// File: rtl/vga_frame_buffer_if.sv
// Pixel-store bus bundle: vga_controller read port, draw-logic write port and clear control.
// The master side belongs to the client logic and the slave side to vga_frame_buffer.
interface vga_frame_buffer_if #(
  parameter int COLOR_DEPTH = 9,
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int Mn          = 19
);
  logic [Mn-1:0]          rd_address;
  logic [COLOR_DEPTH-1:0] rd_color;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [nX-1:0]          wr_x;
  logic [nY-1:0]          wr_y;
  logic [COLOR_DEPTH-1:0] wr_color;
  logic                   clr_start;
  logic [COLOR_DEPTH-1:0] clr_color;
  logic                   busy;
  logic                   clr_done;

  modport master (
    output rd_address, wr_valid, wr_x, wr_y, wr_color, clr_start, clr_color,
    input  rd_color, wr_ready, busy, clr_done
  );

  modport slave (
    input  rd_address, wr_valid, wr_x, wr_y, wr_color, clr_start, clr_color,
    output rd_color, wr_ready, busy, clr_done
  );
endinterface

// File: rtl/vga_frame_buffer.sv
// Frame buffer feeding vga_controller: 1-cycle read port, (x,y) write port, full-frame clear.
// Optional macro FB_RDW_BYPASS_EN: a same-address read during a write returns the new colour.
module vga_frame_buffer #(
  parameter int COLOR_DEPTH = 9,
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int Mn          = 19,
  parameter int COLS        = 640,
  parameter int ROWS        = 480
) (
  input  logic                vga_clock,
  input  logic                resetn,
  vga_frame_buffer_if.slave   fb
);
  // state | meaning
  // IDLE  | pixel writes accepted, waiting for clr_start
  // CLEAR | filling every address with the latched colour, one per cycle
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int              NPIX      = COLS * ROWS;
  localparam logic [Mn-1:0]   NPIX_A    = Mn'(NPIX);
  localparam logic [Mn-1:0]   LAST_ADDR = Mn'(NPIX - 1);
  localparam logic [nX-1:0]   COLS_X    = nX'(COLS);
  localparam logic [nY-1:0]   ROWS_Y    = nY'(ROWS);

  state_t                 state_q, state_d;
  logic [Mn-1:0]          cnt_q, cnt_d;
  logic [COLOR_DEPTH-1:0] fill_q, fill_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;

  logic [COLOR_DEPTH-1:0] mem [NPIX];
  logic [COLOR_DEPTH-1:0] ram_q;

  logic                   wr_in_range;
  logic [Mn-1:0]          wr_addr;
  logic                   we;
  logic [Mn-1:0]          we_addr;
  logic [COLOR_DEPTH-1:0] we_data;
  logic                   rd_in_range;

  always_comb begin
    wr_in_range = (fb.wr_x < COLS_X) && (fb.wr_y < ROWS_Y);
    wr_addr     = Mn'(fb.wr_y) * Mn'(COLS) + Mn'(fb.wr_x);
    rd_in_range = fb.rd_address < NPIX_A;

    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    we      = 1'b0;
    we_addr = wr_addr;
    we_data = fb.wr_color;

    case (state_q)
      IDLE: begin
        // out-of-frame writes still complete the handshake, they just never reach the RAM
        we = fb.wr_valid && wr_in_range;
        if (fb.clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          fill_d  = fb.clr_color;
        end
      end
      CLEAR: begin
        we      = 1'b1;
        we_addr = cnt_q;
        we_data = fill_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == CLEAR);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // RAM array itself is never reset so it maps onto block memory
  always_ff @(posedge vga_clock) begin
    if (we) mem[we_addr] <= we_data;
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) ram_q <= '0;
    else         ram_q <= rd_in_range ? mem[fb.rd_address] : '0;
  end

`ifdef FB_RDW_BYPASS_EN
  logic                   byp_hit_q;
  logic [COLOR_DEPTH-1:0] byp_data_q;

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= we && (we_addr == fb.rd_address);
      byp_data_q <= we_data;
    end
  end

  assign fb.rd_color = byp_hit_q ? byp_data_q : ram_q;
`else
  assign fb.rd_color = ram_q;
`endif

  assign fb.wr_ready = ready_q;
  assign fb.busy     = busy_q;
  assign fb.clr_done = done_q;
endmodule
